seq_shift_src: RTL and testbench

SEQ_SHIFT_SRC -- requirements
Module: seq_shift_src

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_bit_cnt.sv | 33 +++
 rtl/seq_shift_src.sv | 116 +++++++++++
 tb/tb_seq_shift_src.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial pattern source (seq_shift_src, seq_bit_cnt).
// Optional continuous-repeat support in the top is enabled with SEQ_LOOP_EN.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int SEQ_W_DEFAULT = 8;

    // Bits needed to count 0..w-1 without wrapping; never less than one.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_bit_cnt.sv
// Loadable/clearable up-counter with terminal-count flag, tracking the bit position
// of the pattern being shifted out (unaffected by SEQ_LOOP_EN).
module seq_bit_cnt #(
    parameter int CW     = 3,
    parameter int TC_VAL = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(TC_VAL));

endmodule

// File: rtl/seq_shift_src.sv
// Serial pattern source: loads din on start and shifts it out MSB first on ina.
// Define SEQ_LOOP_EN to add the loop port and seamless pattern repetition.
module seq_shift_src
    import seq_pkg::*;
#(
    parameter int W = SEQ_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] din,
`ifdef SEQ_LOOP_EN
    input  logic         loop,
`endif
    output logic         ina,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(W);

    seq_state_t   state;
    logic [W-1:0] shreg;
    logic [CW-1:0] cnt;
    logic         cnt_clr;
    logic         cnt_tc;
`ifdef SEQ_LOOP_EN
    logic [W-1:0] hold;
`endif

    // Counter sits at zero outside SHIFT and restarts after the last bit, so the
    // first bit cycle of every pattern (including repeats) sees cnt == 0.
    assign cnt_clr = (state != SHIFT) || cnt_tc;

    seq_bit_cnt #(
        .CW     (CW),
        .TC_VAL (W - 1)
    ) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .ld     (1'b0),
        .ld_val ({CW{1'b0}}),
        .inc    (1'b1),
        .cnt    (cnt),
        .tc     (cnt_tc)
    );

    // ina mirrors shreg's MSB while shifting: the load edge already drives bit W-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            ina   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SEQ_LOOP_EN
            // NOTE: the holding register is reset along with the rest of the
            // state so a loop restart can never replay stale pre-reset data.
            hold  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    ina  <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        shreg <= din;
                        ina   <= din[W-1];
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SEQ_LOOP_EN
                        hold  <= din;
`endif
                    end
                end
                SHIFT: begin
                    done <= 1'b0;
                    if (cnt_tc) begin
`ifdef SEQ_LOOP_EN
                        if (loop) begin
                            shreg <= hold;
                            ina   <= hold[W-1];
                            done  <= 1'b1;
                        end else
`endif
                        begin
                            state <= DONE;
                            shreg <= '0;
                            ina   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        shreg <= {shreg[W-2:0], 1'b0};
                        ina   <= shreg[W-2];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ina   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ina   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_src.sv
// Self-checking bench for seq_shift_src (W=8) using a per-cycle expected-output queue.
// The repeat scenario is exercised only when SEQ_LOOP_EN is defined.
module tb_seq_shift_src;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] din;
`ifdef SEQ_LOOP_EN
    logic         loop;
`endif
    logic         ina;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    // Expected {ina, busy, done} for each upcoming cycle.
    logic [2:0] sb_q[$];
    logic [2:0] exp_v;

    seq_shift_src #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
`ifdef SEQ_LOOP_EN
        .loop  (loop),
`endif
        .ina   (ina),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_pat(input logic [W-1:0] p);
        for (int b = W - 1; b >= 0; b--) sb_q.push_back({p[b], 1'b1, 1'b0});
        sb_q.push_back(3'b001);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) sb_q.push_back(3'b000);
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        din   = 8'hFF;
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL reset cyc%0d: got ina/busy/done=%b want %b", i, {ina, busy, done}, exp_v);
            end
        end
    endtask

    // Release reset and start on the same edge: the first start must be accepted.
    task automatic test_single();
        rst   = 1'b1;
        start = 1'b1;
        din   = 8'hB4;
        push_pat(8'hB4);
        push_idle(2);
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            exp_v = sb_q.pop_front();
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL single_b4 cyc%0d: got ina/busy/done=%b want %b", i + 1, {ina, busy, done}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        din   = 8'hFF;
        push_pat(8'hFF);
        push_idle(1);
        push_pat(8'h01);
        push_idle(2);
        for (int i = 0; i < 2 * (W + 1) + 3; i++) begin
            @(posedge clk); #1;
            if (i == 0)  din = 8'h01;
            if (i == 10) start = 1'b0;
            exp_v = sb_q.pop_front();
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL b2b cyc%0d: got ina/busy/done=%b want %b", i + 1, {ina, busy, done}, exp_v);
            end
        end
    endtask

    task automatic test_ignore_start();
        start = 1'b1;
        din   = 8'hA5;
        push_pat(8'hA5);
        push_idle(2);
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            if (i >= 2 && i <= 5) begin
                start = ~start;
                din   = ~din ^ W'($urandom_range(0, 255));
            end
            if (i == 6) start = 1'b0;
            exp_v = sb_q.pop_front();
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL ignore_a5 cyc%0d: got ina/busy/done=%b want %b", i + 1, {ina, busy, done}, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        start = 1'b1;
        din   = 8'hF0;
        for (int b = W - 1; b >= W - 4; b--) sb_q.push_back({din[b], 1'b1, 1'b0});
        push_idle(3);
        push_pat(8'h3C);
        push_idle(1);
        for (int i = 0; i < 7 + W + 2; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            if (i == 3) rst = 1'b0;
            if (i == 4) rst = 1'b1;
            if (i == 6) begin
                start = 1'b1;
                din   = 8'h3C;
            end
            if (i == 7) start = 1'b0;
            exp_v = sb_q.pop_front();
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL abort_f0 cyc%0d: got ina/busy/done=%b want %b", i + 1, {ina, busy, done}, exp_v);
            end
        end
    endtask

    task automatic test_zero_pattern();
        start = 1'b1;
        din   = 8'h00;
        push_pat(8'h00);
        push_idle(1);
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            exp_v = sb_q.pop_front();
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL zero cyc%0d: got ina/busy/done=%b want %b", i + 1, {ina, busy, done}, exp_v);
            end
        end
    endtask

    // Downstream "110" detector fed by ina, against the same detector fed by the expected bits.
    task automatic test_detector();
        logic [2:0] dut_win;
        logic [2:0] exp_win;
        logic       dut_det;
        logic       exp_det;
        dut_win = '0;
        exp_win = '0;
        start   = 1'b1;
        din     = 8'b0110_1100;
        push_pat(8'b0110_1100);
        push_idle(1);
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            exp_v   = sb_q.pop_front();
            dut_win = {dut_win[1:0], ina};
            exp_win = {exp_win[1:0], exp_v[2]};
            dut_det = (dut_win == 3'b110);
            exp_det = (exp_win == 3'b110);
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL det_stream cyc%0d: got ina/busy/done=%b want %b", i + 1, {ina, busy, done}, exp_v);
            end
            total++;
            if (dut_det !== exp_det) begin
                bad++;
                $display("FAIL det_out cyc%0d: got %b want %b", i + 1, dut_det, exp_det);
            end
        end
    endtask

`ifdef SEQ_LOOP_EN
    task automatic test_loop();
        logic [W-1:0] p;
        p     = 8'hC3;
        loop  = 1'b1;
        start = 1'b1;
        din   = p;
        for (int r = 0; r < 3; r++)
            for (int b = W - 1; b >= 0; b--)
                sb_q.push_back({p[b], 1'b1, (r > 0 && b == W - 1)});
        sb_q.push_back(3'b001);
        push_idle(1);
        for (int i = 0; i < 3 * W + 2; i++) begin
            @(posedge clk); #1;
            if (i == 0)  start = 1'b0;
            if (i == 17) loop = 1'b0;
            exp_v = sb_q.pop_front();
            total++;
            if ({ina, busy, done} !== exp_v) begin
                bad++;
                $display("FAIL loop_c3 cyc%0d: got ina/busy/done=%b want %b", i + 1, {ina, busy, done}, exp_v);
            end
        end
    endtask
`endif

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        din   = '0;
`ifdef SEQ_LOOP_EN
        loop  = 1'b0;
`endif
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_zero_pattern();
        test_detector();
`ifdef SEQ_LOOP_EN
        test_loop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
